// File: rtl/erx_drp_pkg.sv
// erx_drp_pkg: shared types for the RX PLL DRP reconfiguration sequencer.
// Holds the sequencer state encoding, completion status codes and the
// four-entry divider register table (DRP address, keep mask, encoder select).
// ERX_DRP_READBACK_EN adds the write-verify readback states.
package erx_drp_pkg;

    localparam int unsigned IDX_W  = 2;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DIV_W  = 5;
    localparam int unsigned N_W    = 7;
    localparam int unsigned STAT_W = 3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CHECK,
        ST_RST_WAIT,
        ST_RD,
        ST_RD_WAIT,
        ST_WR,
        ST_WR_WAIT,
        ST_NEXT,
        ST_RELEASE,
        ST_LOCK_WAIT,
        ST_FINISH
`ifdef ERX_DRP_READBACK_EN
        ,
        ST_RB,
        ST_RB_WAIT
`endif
    } state_e;

    typedef enum logic [STAT_W-1:0] {
        STAT_OK          = 3'd0,
        STAT_BAD_DIV     = 3'd1,
        STAT_DRDY_TO     = 3'd2,
        STAT_LOCK_TO     = 3'd3,
        STAT_VERIFY_FAIL = 3'd4
    } status_e;

    // One divider register: where it lives, which bits survive the rewrite,
    // and which encoder output (D or 4D, REG1 or REG2) supplies the new bits.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] keep;
        logic              use_4d;
        logic              is_reg2;
    } drp_entry_t;

    function automatic drp_entry_t drp_entry(input logic [IDX_W-1:0] idx);
        drp_entry_t e;
        case (idx)
            2'd0:    e = '{addr: 7'h10, keep: 16'h1000, use_4d: 1'b0, is_reg2: 1'b0};
            2'd1:    e = '{addr: 7'h11, keep: 16'hFF00, use_4d: 1'b0, is_reg2: 1'b1};
            2'd2:    e = '{addr: 7'h06, keep: 16'h1000, use_4d: 1'b1, is_reg2: 1'b0};
            default: e = '{addr: 7'h07, keep: 16'hFF00, use_4d: 1'b1, is_reg2: 1'b1};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/erx_drp_divenc.sv
// erx_drp_divenc: combinational PLL output-divider encoder.
// Ports: n (divide value, 1..124) -> reg1 (hi/lo count field, bits 11:0),
//        reg2 (edge / nocount / delay field, bits 7:0). All other bits zero.
module erx_drp_divenc
    import erx_drp_pkg::*;
(
    input  logic [N_W-1:0]    n,
    output logic [DATA_W-1:0] reg1,
    output logic [DATA_W-1:0] reg2
);

    logic [5:0] hi;
    logic [5:0] lo;
    logic       nocount;
    logic       edge_bit;

    // Divide-by-1 bypasses the counter; hi/lo are forced to 1 and, since the
    // counter is not used, the half-cycle edge bit stays clear.
    always_comb begin
        nocount  = (n == N_W'(1));
        hi       = nocount ? 6'd1 : n[6:1];
        lo       = nocount ? 6'd1 : 6'(n - {1'b0, n[6:1]});
        edge_bit = n[0] & ~nocount;
        reg1     = {4'b0000, hi, lo};
        reg2     = {8'h00, edge_bit, nocount, 6'b000000};
    end

endmodule

// File: rtl/erx_pll_drp_ctrl.sv
// erx_pll_drp_ctrl: run-time reprogramming of the RX PLL output dividers via DRP.
// Holds the PLL in reset, read-modify-writes four divider registers, releases
// reset and waits for lock, then pulses cfg_done with cfg_status.
// Ports: clk/reset (sync, active high); cfg_start/cfg_div request;
//        cfg_busy/cfg_done/cfg_status completion; pll_reset_req/pll_locked;
//        drp_den/dwe/daddr/di/do/drdy DRP master.
// Optional: ERX_DRP_READBACK_EN verifies every write with a readback.
module erx_pll_drp_ctrl
    import erx_drp_pkg::*;
#(
    parameter int unsigned RST_HOLD = 8,
    parameter int unsigned DRDY_TW  = 8,
    parameter int unsigned LOCK_TW  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_start,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic [STAT_W-1:0] cfg_status,
    output logic              pll_reset_req,
    input  logic              pll_locked,
    output logic              drp_den,
    output logic              drp_dwe,
    output logic [ADDR_W-1:0] drp_daddr,
    output logic [DATA_W-1:0] drp_di,
    input  logic [DATA_W-1:0] drp_do,
    input  logic              drp_drdy
);

    localparam int unsigned HOLD_W    = $clog2(RST_HOLD + 1);
    localparam int unsigned TO_W      = (LOCK_TW > DRDY_TW) ? LOCK_TW : DRDY_TW;
    localparam int unsigned TMR_W     = (TO_W > HOLD_W) ? TO_W : HOLD_W;
    // Last wait-cycle index before expiry: 2^W-1 wait cycles in total.
    localparam int unsigned DRDY_LAST = (1 << DRDY_TW) - 2;
    localparam int unsigned LOCK_LAST = (1 << LOCK_TW) - 2;

    state_e              state_q, state_d;
    status_e             status_q, status_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [TMR_W-1:0]    tmr_q, tmr_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                busy_q, busy_d, done_q, done_d, rstreq_q, rstreq_d;
    logic                den_q, den_d, dwe_q, dwe_d;
    logic [ADDR_W-1:0]   daddr_q, daddr_d;
    logic [DATA_W-1:0]   di_q, di_d;

    logic [DATA_W-1:0]   enc_d_r1, enc_d_r2, enc_4d_r1, enc_4d_r2, new_val;
    drp_entry_t          cur_entry, nxt_entry;
    logic                drdy_expired;

    erx_drp_divenc u_enc_d (
        .n    ({2'b00, div_q}),
        .reg1 (enc_d_r1),
        .reg2 (enc_d_r2)
    );

    erx_drp_divenc u_enc_4d (
        .n    ({div_q, 2'b00}),
        .reg1 (enc_4d_r1),
        .reg2 (enc_4d_r2)
    );

    // New field bits for the register currently being rewritten.
    always_comb begin
        cur_entry = drp_entry(idx_q);
        case ({cur_entry.use_4d, cur_entry.is_reg2})
            2'b00:   new_val = enc_d_r1;
            2'b01:   new_val = enc_d_r2;
            2'b10:   new_val = enc_4d_r1;
            default: new_val = enc_4d_r2;
        endcase
    end

    assign drdy_expired = (tmr_q == TMR_W'(DRDY_LAST));

    // Next state, datapath updates and next-cycle output values.
    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        idx_d    = idx_q;
        tmr_d    = tmr_q;
        div_d    = div_q;
        wdata_d  = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_d  = ST_CHECK;
                    status_d = STAT_OK;
                end
            end
            ST_CHECK: begin
                div_d = cfg_div;
                idx_d = '0;
                tmr_d = '0;
                if (cfg_div == '0) begin
                    state_d  = ST_FINISH;
                    status_d = STAT_BAD_DIV;
                end else begin
                    state_d = ST_RST_WAIT;
                end
            end
            ST_RST_WAIT: begin
                if (tmr_q == TMR_W'(RST_HOLD - 1)) begin
                    state_d = ST_RD;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_RD: begin
                tmr_d   = '0;
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (drp_drdy) begin
                    wdata_d = (drp_do & cur_entry.keep) | new_val;
                    state_d = ST_WR;
                end else if (drdy_expired) begin
                    state_d  = ST_FINISH;
                    status_d = STAT_DRDY_TO;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_WR: begin
                tmr_d   = '0;
                state_d = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (drp_drdy) begin
`ifdef ERX_DRP_READBACK_EN
                    state_d = ST_RB;
`else
                    state_d = ST_NEXT;
`endif
                end else if (drdy_expired) begin
                    state_d  = ST_FINISH;
                    status_d = STAT_DRDY_TO;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
`ifdef ERX_DRP_READBACK_EN
            ST_RB: begin
                tmr_d   = '0;
                state_d = ST_RB_WAIT;
            end
            ST_RB_WAIT: begin
                if (drp_drdy) begin
                    if (drp_do != wdata_q) begin
                        state_d  = ST_FINISH;
                        status_d = STAT_VERIFY_FAIL;
                    end else begin
                        state_d = ST_NEXT;
                    end
                end else if (drdy_expired) begin
                    state_d  = ST_FINISH;
                    status_d = STAT_DRDY_TO;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
`endif
            ST_NEXT: begin
                if (idx_q == IDX_W'(3)) begin
                    state_d = ST_RELEASE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ST_RD;
                end
            end
            ST_RELEASE: begin
                tmr_d   = '0;
                state_d = ST_LOCK_WAIT;
            end
            ST_LOCK_WAIT: begin
                if (pll_locked) begin
                    state_d  = ST_FINISH;
                    status_d = STAT_OK;
                end else if (tmr_q == TMR_W'(LOCK_LAST)) begin
                    state_d  = ST_FINISH;
                    status_d = STAT_LOCK_TO;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they can be registered.
        nxt_entry = drp_entry(idx_d);
        busy_d    = (state_d != ST_IDLE) && (state_d != ST_FINISH);
        done_d    = (state_d == ST_FINISH);
        rstreq_d  = (state_d == ST_RST_WAIT) || (state_d == ST_RD) ||
                    (state_d == ST_RD_WAIT)  || (state_d == ST_WR) ||
                    (state_d == ST_WR_WAIT)  || (state_d == ST_NEXT);
        den_d     = (state_d == ST_RD) || (state_d == ST_WR);
`ifdef ERX_DRP_READBACK_EN
        rstreq_d  = rstreq_d || (state_d == ST_RB) || (state_d == ST_RB_WAIT);
        den_d     = den_d || (state_d == ST_RB);
`endif
        dwe_d     = (state_d == ST_WR);
        daddr_d   = den_d ? nxt_entry.addr : '0;
        di_d      = dwe_d ? wdata_d : '0;
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            status_q <= STAT_OK;
            idx_q    <= '0;
            tmr_q    <= '0;
            div_q    <= '0;
            wdata_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rstreq_q <= 1'b0;
            den_q    <= 1'b0;
            dwe_q    <= 1'b0;
            daddr_q  <= '0;
            di_q     <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            idx_q    <= idx_d;
            tmr_q    <= tmr_d;
            div_q    <= div_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rstreq_q <= rstreq_d;
            den_q    <= den_d;
            dwe_q    <= dwe_d;
            daddr_q  <= daddr_d;
            di_q     <= di_d;
        end
    end

    assign cfg_busy      = busy_q;
    assign cfg_done      = done_q;
    assign cfg_status    = status_q;
    assign pll_reset_req = rstreq_q;
    assign drp_den       = den_q;
    assign drp_dwe       = dwe_q;
    assign drp_daddr     = daddr_q;
    assign drp_di        = di_q;

endmodule

// File: tb/tb_erx_pll_drp_ctrl.sv
// tb_erx_pll_drp_ctrl: directed bench for erx_pll_drp_ctrl with a DRP slave
// and PLL lock model; expected register writes are hand-computed.
// Honours ERX_DRP_READBACK_EN (adds the verify-fail case).
module tb_erx_pll_drp_ctrl;

    localparam int RST_HOLD = 8;
    localparam int DRDY_TW  = 8;
    localparam int LOCK_TW  = 10;
`ifdef ERX_DRP_READBACK_EN
    localparam int REG_CYC  = 7;
`else
    localparam int REG_CYC  = 5;
`endif
    // CHECK + hold + 4 registers + RELEASE/LOCK_WAIT/FINISH
    localparam int NOM_LAT  = 1 + RST_HOLD + 4 * REG_CYC + 3;
    // CHECK + hold + RD/RD_WAIT/WR, 255 WR_WAIT cycles, FINISH
    localparam int DRDY_LAT = 1 + RST_HOLD + 3 + 255 + 1;
    // everything up to RELEASE, 1023 LOCK_WAIT cycles, FINISH
    localparam int LOCK_LAT = 1 + RST_HOLD + 4 * REG_CYC + 1 + 1023 + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_start;
    logic [4:0]  cfg_div;
    logic        cfg_busy;
    logic        cfg_done;
    logic [2:0]  cfg_status;
    logic        pll_reset_req;
    logic        pll_locked;
    logic        drp_den;
    logic        drp_dwe;
    logic [6:0]  drp_daddr;
    logic [15:0] drp_di;
    logic [15:0] drp_do;
    logic        drp_drdy;

    int tests_run    = 0;
    int tests_failed = 0;

    // DRP slave / PLL model state
    logic [15:0] mem     [0:127];
    logic        written [0:127];
    logic [6:0]  wr_a    [0:15];
    logic [15:0] wr_d    [0:15];
    logic        wr_r    [0:15];
    int          wr_n       = 0;
    int          den_cnt    = 0;
    int          done_cnt   = 0;
    int          withhold_n = 0;
    int          lock_delay = 0;
    int          lock_cnt   = 0;
    logic        rst_seen   = 1'b0;
    logic        corrupt_06 = 1'b0;
    logic        pend       = 1'b0;
    logic [15:0] pend_do    = 16'h0;

    int cyc;

    erx_pll_drp_ctrl #(
        .RST_HOLD (RST_HOLD),
        .DRDY_TW  (DRDY_TW),
        .LOCK_TW  (LOCK_TW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cfg_start     (cfg_start),
        .cfg_div       (cfg_div),
        .cfg_busy      (cfg_busy),
        .cfg_done      (cfg_done),
        .cfg_status    (cfg_status),
        .pll_reset_req (pll_reset_req),
        .pll_locked    (pll_locked),
        .drp_den       (drp_den),
        .drp_dwe       (drp_dwe),
        .drp_daddr     (drp_daddr),
        .drp_di        (drp_di),
        .drp_do        (drp_do),
        .drp_drdy      (drp_drdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // DRP slave answers one cycle after den; PLL locks lock_delay cycles
    // after reset release (never when lock_delay < 0).
    initial begin : drp_model
        drp_drdy   = 1'b0;
        drp_do     = 16'h0;
        pll_locked = 1'b0;
        forever begin
            @(negedge clk);
            drp_drdy = 1'b0;
            if (pend) begin
                drp_drdy = 1'b1;
                drp_do   = pend_do;
                pend     = 1'b0;
            end
            if (drp_den) begin
                den_cnt++;
                if (drp_dwe) begin
                    if (wr_n < 16) begin
                        wr_a[wr_n] = drp_daddr;
                        wr_d[wr_n] = drp_di;
                        wr_r[wr_n] = pll_reset_req;
                    end
                    wr_n++;
                    mem[drp_daddr]     = drp_di;
                    written[drp_daddr] = 1'b1;
                    pend_do            = 16'h0;
                end else begin
                    pend_do = mem[drp_daddr];
                    if (corrupt_06 && drp_daddr == 7'h06 && written[7'h06])
                        pend_do = pend_do ^ 16'h0001;
                end
                if (den_cnt != withhold_n) pend = 1'b1;
            end
            if (pll_reset_req) begin
                rst_seen   = 1'b1;
                pll_locked = 1'b0;
                lock_cnt   = 0;
            end else if (lock_delay >= 0) begin
                if (lock_cnt >= lock_delay) pll_locked = 1'b1;
                else lock_cnt++;
            end else begin
                pll_locked = 1'b0;
            end
            if (cfg_done) done_cnt++;
        end
    end

    task automatic setup(input logic [15:0] r1, input logic [15:0] r2,
                         input int ld, input int wh, input logic cor);
        @(posedge clk);
        #1;
        for (int i = 0; i < 128; i++) begin
            mem[i]     = 16'h0;
            written[i] = 1'b0;
        end
        mem[7'h10] = r1;
        mem[7'h06] = r1;
        mem[7'h11] = r2;
        mem[7'h07] = r2;
        wr_n       = 0;
        den_cnt    = 0;
        done_cnt   = 0;
        rst_seen   = 1'b0;
        lock_delay = ld;
        withhold_n = wh;
        corrupt_06 = cor;
    endtask

    // Returns at the negedge of the CHECK cycle (cycle 1).
    task automatic start_req(input logic [4:0] d);
        @(negedge clk);
        cfg_div   = d;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit, input int c0, output int c);
        c = c0;
        while (!cfg_done && c < limit) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_done"}, 32'(cfg_done), 32'd1);
    endtask

    task automatic check_writes(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                                input logic [15:0] e2, input logic [15:0] e3);
        logic [6:0]  ea [0:3];
        logic [15:0] ed [0:3];
        ea[0] = 7'h10; ea[1] = 7'h11; ea[2] = 7'h06; ea[3] = 7'h07;
        ed[0] = e0;    ed[1] = e1;    ed[2] = e2;    ed[3] = e3;
        check({tag, "_nwr"}, 32'(wr_n), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_addr%0d", tag, i), 32'(wr_a[i]), 32'(ea[i]));
            check($sformatf("%s_data%0d", tag, i), 32'(wr_d[i]), 32'(ed[i]));
            check($sformatf("%s_rstreq%0d", tag, i), 32'(wr_r[i]), 32'd1);
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests run %0d", tests_run);
        $fatal(1);
    end

    initial begin : stim
        reset     = 1'b1;
        cfg_start = 1'b0;
        cfg_div   = 5'd0;
        repeat (3) @(negedge clk);
        check("rst_outs", {cfg_busy, cfg_done, cfg_status, pll_reset_req, drp_den, drp_dwe,
                           drp_daddr, drp_di}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(cfg_busy), 32'd0);

        // D=2 over nonzero old contents, lock after 10 cycles
        setup(16'h1FFF, 16'hABFF, 10, 0, 1'b0);
        start_req(5'd2);
        check("d2_busy_check", 32'(cfg_busy), 32'd1);
        wait_done("d2", 500, 1, cyc);
        check("d2_status", 32'(cfg_status), 32'd0);
        check("d2_busy_at_done", 32'(cfg_busy), 32'd0);
        check("d2_rstreq_at_done", 32'(pll_reset_req), 32'd0);
        check_writes("d2", 16'h1041, 16'hAB00, 16'h1104, 16'hAB00);
        // start in the done cycle is ignored
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        check("fin_start_busy0", 32'(cfg_busy), 32'd0);
        @(negedge clk);
        check("fin_start_busy1", 32'(cfg_busy), 32'd0);

        // D=1: bypass encoding
        setup(16'h0000, 16'h0000, 0, 0, 1'b0);
        start_req(5'd1);
        wait_done("d1", 500, 1, cyc);
        check("d1_status", 32'(cfg_status), 32'd0);
        check_writes("d1", 16'h0041, 16'h0040, 16'h0082, 16'h0000);

        // D=3: odd divide sets edge
        setup(16'h0000, 16'h0000, 0, 0, 1'b0);
        start_req(5'd3);
        wait_done("d3", 500, 1, cyc);
        check_writes("d3", 16'h0042, 16'h0080, 16'h0186, 16'h0000);

        // D=5, nominal latency (4D=20)
        setup(16'h0000, 16'h0000, 0, 0, 1'b0);
        start_req(5'd5);
        wait_done("d5", 500, 1, cyc);
        check("d5_latency", 32'(cyc), 32'(NOM_LAT));
        check_writes("d5", 16'h0083, 16'h0080, 16'h028A, 16'h0000);

        // D=0: bad divide, no DRP traffic, no PLL reset
        setup(16'h0000, 16'h0000, 0, 0, 1'b0);
        start_req(5'd0);
        wait_done("d0", 50, 1, cyc);
        check("d0_latency", 32'(cyc), 32'd2);
        check("d0_status", 32'(cfg_status), 32'd1);
        check("d0_den_cnt", 32'(den_cnt), 32'd0);
        check("d0_rst_seen", 32'(rst_seen), 32'd0);

        // DRDY withheld on the second den
        setup(16'h0000, 16'h0000, 0, 2, 1'b0);
        start_req(5'd2);
        wait_done("drdy_to", 2000, 1, cyc);
        check("drdy_to_latency", 32'(cyc), 32'(DRDY_LAT));
        check("drdy_to_status", 32'(cfg_status), 32'd2);
        check("drdy_to_rstreq", 32'(pll_reset_req), 32'd0);

        // lock never comes
        setup(16'h0000, 16'h0000, -1, 0, 1'b0);
        start_req(5'd2);
        wait_done("lock_to", 5000, 1, cyc);
        check("lock_to_latency", 32'(cyc), 32'(LOCK_LAT));
        check("lock_to_status", 32'(cfg_status), 32'd3);
        check("lock_to_rstreq", 32'(pll_reset_req), 32'd0);

        // second start mid-sequence is ignored
        setup(16'h1FFF, 16'hABFF, 0, 0, 1'b0);
        start_req(5'd2);
        repeat (10) @(negedge clk);
        cfg_div   = 5'd7;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        wait_done("restart", 500, 12, cyc);
        check("restart_latency", 32'(cyc), 32'(NOM_LAT));
        check("restart_status", 32'(cfg_status), 32'd0);
        check_writes("restart", 16'h1041, 16'hAB00, 16'h1104, 16'hAB00);
        @(negedge clk);
        check("restart_done_cnt", 32'(done_cnt), 32'd1);

        // reset during WR_WAIT
        setup(16'h0000, 16'h0000, 0, 0, 1'b0);
        start_req(5'd2);
        cyc = 1;
        while (!drp_dwe && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("rstmid_wr_seen", 32'(drp_dwe), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rstmid_outs", {cfg_busy, cfg_done, cfg_status, pll_reset_req, drp_den, drp_dwe,
                              drp_daddr, drp_di}, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("rstmid_no_done", 32'(done_cnt), 32'd0);
        check("rstmid_busy", 32'(cfg_busy), 32'd0);

`ifdef ERX_DRP_READBACK_EN
        // corrupted readback of 0x06
        setup(16'h0000, 16'h0000, 0, 0, 1'b1);
        start_req(5'd2);
        wait_done("verify", 500, 1, cyc);
        check("verify_status", 32'(cfg_status), 32'd4);
        check("verify_nwr", 32'(wr_n), 32'd3);
        check("verify_rstreq", 32'(pll_reset_req), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
